// File: rtl/lsu_mem_master_if.sv
// Core-side request/response and memory-side strobe bundle for lsu_mem_master.
// Latency: none (wires only).
// Backpressure: core side uses busy as a request gate; memory side has no backpressure.
interface lsu_mem_master_if #(
  parameter int ADDR_W = 32
);
  // core request
  logic              req;
  logic              we;
  logic [1:0]        size;
  logic              sign_ext;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  // core response
  logic              busy;
  logic              done;
  logic              err;
  logic [31:0]       rdata;
  // data memory
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  // the load/store unit drives the memory strobes and the core response
  modport master (
    input  req, we, size, sign_ext, addr, wdata, mem_rdata,
    output busy, done, err, rdata, mem_read, mem_write, mem_addr, mem_wdata
  );

  // core plus memory environment around the unit
  modport slave (
    output req, we, size, sign_ext, addr, wdata, mem_rdata,
    input  busy, done, err, rdata, mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/lsu_mem_master.sv
// Load/store unit: byte/half/word core accesses to a big-endian word memory, RMW for sub-word stores.
// Latency: accept->done = RD_LAT+1 load, 2 word store, RD_LAT+2 sub-word store, 1 misaligned trap.
// Backpressure: busy high from accept until the cycle after done; req while busy is dropped.
// Optional: LSU_MISALIGN_TRAP_EN makes misaligned half/word accesses complete with err=1.
module lsu_mem_master #(
  parameter int ADDR_W = 32,
  parameter int RD_LAT = 1
) (
  input logic              clk,
  input logic              rst_n,
  lsu_mem_master_if.master bus
);

  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_we;
  logic [1:0]        r_size;
  logic              r_sign;
  logic [1:0]        r_off;
  logic [31:0]       r_wdata;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_err;
  logic [31:0]       r_rdata;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_mem_wdata;

  logic              w_misal;
  logic              w_rd_last;
  logic              w_busy;
  logic              w_done;
  logic              w_mem_read;
  logic              w_mem_write;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_load;
  logic [31:0]       w_merge;

`ifdef LSU_MISALIGN_TRAP_EN
  // halfword must sit on an even byte, word (size 10 or 11) on offset 0
  assign w_misal = ((bus.size == 2'b01) && bus.addr[0]) ||
                   (bus.size[1] && (bus.addr[1:0] != 2'b00));
`else
  // low address bits that don't fit the access size are simply ignored
  assign w_misal = 1'b0;
`endif

  assign w_rd_last = (r_cnt == CNT_W'(RD_LAT - 1));

  // big-endian lane select: byte offset n lives at bit 8*(3-n), i.e. {~off,3'b0}
  always_comb begin
    w_byte  = bus.mem_rdata[{~r_off, 3'b000} +: 8];
    w_half  = bus.mem_rdata[{~r_off[1], 4'b0000} +: 16];
    w_load  = bus.mem_rdata;
    w_merge = bus.mem_rdata;
    case (r_size)
      2'b00: begin
        w_load = {{24{r_sign & w_byte[7]}}, w_byte};
        w_merge[{~r_off, 3'b000} +: 8] = r_wdata[7:0];
      end
      2'b01: begin
        w_load = {{16{r_sign & w_half[15]}}, w_half};
        w_merge[{~r_off[1], 4'b0000} +: 16] = r_wdata[15:0];
      end
      default: begin
        w_load  = bus.mem_rdata;
        w_merge = r_wdata;
      end
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // next state and state-decoded strobes; strobes are pure state decodes so reset clears them at once
  always_comb begin
    w_next      = r_state;
    w_busy      = 1'b1;
    w_done      = 1'b0;
    w_mem_read  = 1'b0;
    w_mem_write = 1'b0;
    case (r_state)
      IDLE: begin
        w_busy = 1'b0;
        if (bus.req) begin
          if (w_misal)                    w_next = DONE;
          else if (!bus.we || !bus.size[1]) w_next = RD;
          else                            w_next = WR;
        end
      end
      RD: begin
        w_mem_read = 1'b1;
        if (w_rd_last) w_next = r_we ? WR : DONE;
      end
      WR: begin
        w_mem_write = 1'b1;
        w_next      = DONE;
      end
      DONE: begin
        w_done = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // request latch, read-wait counter, load capture and store merge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we        <= 1'b0;
      r_size      <= 2'b00;
      r_sign      <= 1'b0;
      r_off       <= 2'b00;
      r_wdata     <= 32'h0;
      r_cnt       <= '0;
      r_err       <= 1'b0;
      r_rdata     <= 32'h0;
      r_mem_addr  <= '0;
      r_mem_wdata <= 32'h0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.req) begin
            r_we    <= bus.we;
            r_size  <= bus.size;
            r_sign  <= bus.sign_ext;
            r_off   <= bus.addr[1:0];
            r_wdata <= bus.wdata;
            r_err   <= w_misal;
            r_cnt   <= '0;
            // a trapped access never touches the memory bus, so its address is left alone
            if (!w_misal) begin
              r_mem_addr <= {bus.addr[ADDR_W-1:2], 2'b00};
              if (bus.we && bus.size[1]) r_mem_wdata <= bus.wdata;
            end
          end
        end
        RD: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_rd_last) begin
            if (r_we) r_mem_wdata <= w_merge;
            else      r_rdata     <= w_load;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = w_busy;
  assign bus.done      = w_done;
  assign bus.err       = w_done & r_err;
  assign bus.rdata     = r_rdata;
  assign bus.mem_read  = w_mem_read;
  assign bus.mem_write = w_mem_write;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Bench for lsu_mem_master: directed load/store vectors against a falling-edge word memory.
// Expected completions and memory writes are queued at issue and popped by a monitor.
// Covers extension, RMW merge, word store, misalignment, busy-drop and mid-read reset.
module tb_lsu_mem_master;
  localparam int ADDR_W = 32;

  typedef struct {
    string       name;
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          nrd;
    int          nwr;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wexp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lsu_mem_master_if #(.ADDR_W(ADDR_W)) bus();

  lsu_mem_master #(.ADDR_W(ADDR_W), .RD_LAT(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t        exp_q[$];
  wexp_t       wr_q[$];
  int          total = 0;
  int          bad = 0;
  int          ncyc = 0;
  int          acc_cyc = 0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  logic [31:0] mem [16];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, want);
    end
  endtask

  // data memory: samples strobes on the falling edge
  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    mem[4] = 32'h801234F5;
    bus.mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (bus.mem_read)  bus.mem_rdata = mem[bus.mem_addr[5:2]];
      if (bus.mem_write) mem[bus.mem_addr[5:2]] = bus.mem_wdata;
    end
  end

  // monitor: checks memory writes and completions against the queues
  always @(negedge clk) begin
    exp_t  e;
    wexp_t w;
    if (!rst_n) begin
      rd_cnt = 0;
      wr_cnt = 0;
    end else begin
      ncyc++;
      if (bus.mem_read && bus.mem_write) check("rd_wr_overlap", 32'd1, 32'd0);
      if (bus.mem_read) rd_cnt++;
      if (bus.mem_write) begin
        wr_cnt++;
        if (wr_q.size() == 0) check("unexpected_write", 32'd1, 32'd0);
        else begin
          w = wr_q.pop_front();
          check("wr_addr", bus.mem_addr, w.addr);
          check("wr_data", bus.mem_wdata, w.data);
        end
      end
      if (bus.done) begin
        if (exp_q.size() == 0) check("unexpected_done", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          check({e.name, "_err"},   {31'd0, bus.err}, {31'd0, e.err});
          check({e.name, "_rdata"}, bus.rdata, e.rdata);
          check({e.name, "_lat"},   ncyc - acc_cyc, e.lat);
          check({e.name, "_nrd"},   rd_cnt, e.nrd);
          check({e.name, "_nwr"},   wr_cnt, e.nwr);
        end
        rd_cnt = 0;
        wr_cnt = 0;
      end
    end
  end

  task automatic wait_idle(input string nm);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (bus.busy && k < 30);
    if (bus.busy) check({nm, "_timeout"}, 32'd1, 32'd0);
  endtask

  task automatic drive(input logic we, input logic [1:0] sz, input logic sx,
                       input logic [31:0] a, input logic [31:0] wd);
    bus.req      = 1'b1;
    bus.we       = we;
    bus.size     = sz;
    bus.sign_ext = sx;
    bus.addr     = a;
    bus.wdata    = wd;
  endtask

  task automatic expect_op(input string nm, input logic xerr, input logic [31:0] xrd,
                           input int xlat, input int xnrd, input int xnwr,
                           input logic [31:0] waddr, input logic [31:0] xwd);
    exp_t  e;
    wexp_t w;
    e.name = nm; e.err = xerr; e.rdata = xrd; e.lat = xlat; e.nrd = xnrd; e.nwr = xnwr;
    exp_q.push_back(e);
    if (xnwr != 0) begin
      w.addr = {waddr[31:2], 2'b00};
      w.data = xwd;
      wr_q.push_back(w);
    end
  endtask

  // one complete request; caller sits on a falling edge with busy low
  task automatic op(input string nm, input logic we, input logic [1:0] sz, input logic sx,
                    input logic [31:0] a, input logic [31:0] wd,
                    input logic xerr, input logic [31:0] xrd, input int xlat,
                    input int xnrd, input int xnwr, input logic [31:0] xwd);
    expect_op(nm, xerr, xrd, xlat, xnrd, xnwr, a, xwd);
    drive(we, sz, sx, a, wd);
    @(posedge clk);
    acc_cyc = ncyc;
    #1 bus.req = 1'b0;
    wait_idle(nm);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_busy"},      {31'd0, bus.busy},      32'd0);
    check({pfx, "_done"},      {31'd0, bus.done},      32'd0);
    check({pfx, "_err"},       {31'd0, bus.err},       32'd0);
    check({pfx, "_mem_read"},  {31'd0, bus.mem_read},  32'd0);
    check({pfx, "_mem_write"}, {31'd0, bus.mem_write}, 32'd0);
    check({pfx, "_rdata"},     bus.rdata,     32'd0);
    check({pfx, "_mem_addr"},  bus.mem_addr,  32'd0);
    check({pfx, "_mem_wdata"}, bus.mem_wdata, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req = 1'b0; bus.we = 1'b0; bus.size = 2'b00; bus.sign_ext = 1'b0;
    bus.addr = 32'h0; bus.wdata = 32'h0;
    #1 check_reset_outputs("rst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    //  name        we  sz     sx    addr    wdata          err   rdata          lat rd wr wdata
    op("ld_w10",   0, 2'b10, 0, 32'h10, 32'h0,        0, 32'h801234F5, 2, 1, 0, 32'h0);
    op("ld_sb10",  0, 2'b00, 1, 32'h10, 32'h0,        0, 32'hFFFFFF80, 2, 1, 0, 32'h0);
    op("ld_ub13",  0, 2'b00, 0, 32'h13, 32'h0,        0, 32'h000000F5, 2, 1, 0, 32'h0);
    op("ld_ub10",  0, 2'b00, 0, 32'h10, 32'h0,        0, 32'h00000080, 2, 1, 0, 32'h0);
    op("ld_sh12",  0, 2'b01, 1, 32'h12, 32'h0,        0, 32'h000034F5, 2, 1, 0, 32'h0);
    op("ld_uh10",  0, 2'b01, 0, 32'h10, 32'h0,        0, 32'h00008012, 2, 1, 0, 32'h0);
    op("ld_sh10",  0, 2'b01, 1, 32'h10, 32'h0,        0, 32'hFFFF8012, 2, 1, 0, 32'h0);
    op("st_b11",   1, 2'b00, 0, 32'h11, 32'h000000AB, 0, 32'hFFFF8012, 3, 1, 1, 32'h80AB34F5);
    op("ld_w10b",  0, 2'b10, 0, 32'h10, 32'h0,        0, 32'h80AB34F5, 2, 1, 0, 32'h0);
    op("st_w10",   1, 2'b10, 0, 32'h10, 32'h801234F5, 0, 32'h80AB34F5, 2, 0, 1, 32'h801234F5);
    op("st_h12",   1, 2'b01, 0, 32'h12, 32'h0000BEEF, 0, 32'h80AB34F5, 3, 1, 1, 32'h8012BEEF);
    op("ld_w10c",  0, 2'b10, 0, 32'h10, 32'h0,        0, 32'h8012BEEF, 2, 1, 0, 32'h0);
    op("st_w10b",  1, 2'b11, 0, 32'h10, 32'h801234F5, 0, 32'h8012BEEF, 2, 0, 1, 32'h801234F5);
    op("st_w14",   1, 2'b10, 0, 32'h14, 32'hDEADBEEF, 0, 32'h8012BEEF, 2, 0, 1, 32'hDEADBEEF);
    op("ld_w14",   0, 2'b10, 0, 32'h14, 32'h0,        0, 32'hDEADBEEF, 2, 1, 0, 32'h0);
    op("st_b17",   1, 2'b00, 0, 32'h17, 32'h12345677, 0, 32'hDEADBEEF, 3, 1, 1, 32'hDEADBE77);
`ifdef LSU_MISALIGN_TRAP_EN
    op("ld_uh11",  0, 2'b01, 0, 32'h11, 32'h0,        1, 32'hDEADBEEF, 1, 0, 0, 32'h0);
    op("st_w16",   1, 2'b10, 0, 32'h16, 32'h11223344, 1, 32'hDEADBEEF, 1, 0, 0, 32'h0);
    op("ld_w14b",  0, 2'b10, 0, 32'h14, 32'h0,        0, 32'hDEADBE77, 2, 1, 0, 32'h0);
`else
    op("ld_uh11",  0, 2'b01, 0, 32'h11, 32'h0,        0, 32'h00008012, 2, 1, 0, 32'h0);
    op("st_w16",   1, 2'b10, 0, 32'h16, 32'h11223344, 0, 32'h00008012, 2, 0, 1, 32'h11223344);
    op("ld_w14b",  0, 2'b10, 0, 32'h14, 32'h0,        0, 32'h11223344, 2, 1, 0, 32'h0);
`endif

    // req held through RD and DONE of a load: both extra requests must be dropped
    expect_op("ld_busy", 0, 32'h801234F5, 2, 1, 0, 32'h10, 32'h0);
    drive(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    @(posedge clk);
    acc_cyc = ncyc;
    #1 drive(1'b1, 2'b10, 1'b0, 32'h14, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1 bus.req = 1'b0;
    wait_idle("ld_busy");
`ifdef LSU_MISALIGN_TRAP_EN
    op("ld_w14c",  0, 2'b10, 0, 32'h14, 32'h0,        0, 32'hDEADBE77, 2, 1, 0, 32'h0);
`else
    op("ld_w14c",  0, 2'b10, 0, 32'h14, 32'h0,        0, 32'h11223344, 2, 1, 0, 32'h0);
`endif

    // reset while the read strobe is up: everything clears immediately, no done follows
    drive(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    @(posedge clk);
    #1 bus.req = 1'b0;
    check("mid_rd_mem_read", {31'd0, bus.mem_read}, 32'd1);
    rst_n = 1'b0;
    #1 check_reset_outputs("midrst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    op("ld_w10d",  0, 2'b10, 0, 32'h10, 32'h0,        0, 32'h801234F5, 2, 1, 0, 32'h0);

    repeat (3) @(negedge clk);
    check("exp_q_left", exp_q.size(), 32'd0);
    check("wr_q_left",  wr_q.size(),  32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/lsu_mem_master.md
Name: lsu_mem_master

Overview:
- Load/store unit sitting between the core datapath and the word-wide, byte-addressed, big-endian data memory.
- The data memory samples on the falling edge; this unit is the initiator that drives its read/write strobes.
- Converts core byte, halfword and word loads/stores into single-word memory transactions.
- Sub-word stores use read-modify-write; loads return sign- or zero-extended data.

Parameters:
- ADDR_W, 32, core and memory address width.
- RD_LAT, 1, rising edges from the first mem_read cycle until mem_rdata is valid; minimum 1.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  1  request strobe; accepted only when busy=0.
- we  in  1  1 = store, 0 = load.
- size  in  2  00 byte, 01 halfword, 10 word; 11 is treated as word.
- sign_ext  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- addr  in  ADDR_W  byte address.
- wdata  in  32  store data, right-justified.
- busy  out  1  high from the accept edge until the cycle after done.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done; misaligned access.
- rdata  out  32  load result; held until the next done.
- mem_read  out  1  drives the memory read enable.
- mem_write  out  1  drives the memory write enable.
- mem_addr  out  ADDR_W  word-aligned address, addr with bits [1:0] cleared.
- mem_wdata  out  32  word to the memory.
- mem_rdata  in  32  word from the memory.

Behaviour:
- Reset (asynchronous): state IDLE; busy, done, err, mem_read, mem_write = 0; rdata, mem_addr, mem_wdata = 0; wait counter = 0.
- Byte lanes are big-endian: offset 0 = [31:24], 1 = [23:16], 2 = [15:8], 3 = [7:0]. Halfword offset 0 = [31:16], offset 2 = [15:0].
- States: IDLE, RD, WR, DONE.
- IDLE:
  - On req=1, latch we, size, sign_ext, addr, wdata; set busy.
  - Misaligned access goes to DONE with err=1 and issues no memory strobe.
  - Load or sub-word store goes to RD.
  - Word store goes to WR.
- RD:
  - mem_read=1 for exactly RD_LAT cycles; mem_addr = aligned address.
  - On the edge ending the last RD cycle, mem_rdata is captured:
    - load: extract the lane, extend per sign_ext, write rdata, go to DONE;
    - store: merge wdata into the selected lane(s), keep the other lanes, go to WR.
- WR:
  - mem_write=1 for exactly one cycle; mem_wdata = merged word, or wdata for a word store.
  - Go to DONE.
- DONE: done=1 for one cycle; err valid; return to IDLE with busy=0.
- mem_read and mem_write are never high together. Both are low in IDLE and DONE.
- mem_addr and mem_wdata hold their last values when idle.
- Latency from the accept edge to done high (RD_LAT=1):
  - load: 2 cycles;
  - word store: 2 cycles;
  - sub-word store: 3 cycles;
  - error: 1 cycle.
- req while busy=1 is ignored and not queued. req in the same cycle as done is also ignored, since busy is still high.
- Store into an unselected lane: the lane's read-back value is written unchanged.
- Reset mid-operation aborts immediately, with no done pulse. A write already issued is not undone.
- rdata is not updated by stores or error completions.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: halfword with addr[0]=1, or word with addr[1:0]!=0, completes with err=1 and no memory access.
- Undefined: offending low address bits are ignored (halfword uses addr[1], word uses offset 0); err is tied to 0.

Test Plan:
- Preload word 0x10 with bytes 80,12,34,F5. Load word 0x10 -> rdata=0x801234F5; one mem_read cycle; done 2 cycles after accept; err=0.
- Signed byte load 0x10 -> 0xFFFFFF80. Unsigned byte load 0x13 -> 0x000000F5. Signed halfword load 0x12 -> 0x000034F5. Unsigned halfword load 0x10 -> 0x00008012.
- Byte store 0x11, wdata=0x000000AB -> one mem_read then one mem_write of 0x80AB34F5; a following word load of 0x10 returns 0x80AB34F5.
- Halfword store 0x12, wdata=0xBEEF -> memory 0x8012BEEF. Word store 0x14 = 0xDEADBEEF -> no mem_read, one mem_write, done 2 cycles after accept.
- Halfword load 0x11:
  - with LSU_MISALIGN_TRAP_EN: done and err=1 one cycle after accept; mem_read and mem_write stay 0; rdata unchanged;
  - without the macro: rdata=0x00008012.
- Pulse req again while busy -> ignored. Assert rst_n low during RD -> all outputs 0 immediately, no done. A fresh word load 0x10 afterwards returns 0x801234F5.
